// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer slice.
// Optional parity is enabled by defining PISO_PARITY_EN.
package piso_pkg;

    localparam int PISO_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable WIDTH-bit shifter; LSB_FIRST picks which end is presented on bit_out.
// Used by piso_serializer (PISO_PARITY_EN does not affect this block).
module piso_shift_reg
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             bit_out
);

    logic [WIDTH-1:0] data;

    // Load wins over shift so a reload on the last bit never loses the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= din;
        end else if (shift) begin
            if (LSB_FIRST) begin
                data <= {1'b0, data[WIDTH-1:1]};
            end else begin
                data <= {data[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign bit_out = LSB_FIRST ? data[0] : data[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter with valid/ready input and framing strobes.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] par_in,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    piso_state_t      state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;

    logic             accept;
    logic             on_last_data;
    logic             frame_end;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] load_data;
    logic             data_bit;

    assign par_ready    = !hold_full;
    assign accept       = par_valid && !hold_full;
    assign on_last_data = (state == SHIFT) && (bit_cnt == LAST_CNT);

`ifdef PISO_PARITY_EN
    assign frame_end = (state == PARITY);
`else
    assign frame_end = on_last_data;
`endif

    // The hold register is always empty in IDLE, so hold_full alone selects the source.
    assign load      = ((state == IDLE) && accept) || (frame_end && (hold_full || accept));
    assign load_data = hold_full ? hold_reg : par_in;
    assign shift     = (state == SHIFT) && !on_last_data;

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .shift   (shift),
        .din     (load_data),
        .bit_out (data_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else if (load) begin
            state   <= SHIFT;
            bit_cnt <= '0;
        end else if (shift) begin
            bit_cnt <= bit_cnt + CW'(1);
`ifdef PISO_PARITY_EN
        end else if (on_last_data) begin
            state   <= PARITY;
            bit_cnt <= bit_cnt + CW'(1);
`endif
        end else if (frame_end) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end
    end

    // A word goes to the hold register only when it cannot go straight into the shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else if (load && hold_full) begin
            hold_full <= 1'b0;
        end else if (accept && !load) begin
            hold_reg  <= par_in;
            hold_full <= 1'b1;
        end
    end

`ifdef PISO_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_bit <= 1'b0;
        end else if (load) begin
            parity_bit <= ^load_data;
        end
    end

    assign ser_out  = (state == PARITY) ? parity_bit : ((state == SHIFT) && data_bit);
    assign ser_last = (state == PARITY);
`else
    assign ser_out  = (state == SHIFT) && data_bit;
    assign ser_last = on_last_data;
`endif

    assign ser_valid = (state != IDLE);
    assign ser_first = (state == SHIFT) && (bit_cnt == '0);
    assign busy      = (state != IDLE) || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: LSB-first and MSB-first instances against a frame-queue model.
// Follows PISO_PARITY_EN the same way the design does.
`timescale 1ns/1ps
module tb_piso_serializer;

    localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_LEN = WIDTH + (PAR_EN ? 1 : 0);

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } exp_bit_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             par_valid = 1'b0;
    logic [WIDTH-1:0] par_in = '0;

    logic lsb_ready, lsb_out, lsb_valid, lsb_first, lsb_last, lsb_busy;
    logic msb_ready, msb_out, msb_valid, msb_first, msb_last, msb_busy;

    exp_bit_t q_lsb[$];
    exp_bit_t q_msb[$];
    exp_bit_t cur_lsb;
    exp_bit_t cur_msb;
    logic     exp_valid;
    int       pending;
    int       checks;
    int       failures;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) u_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .par_in    (par_in),
        .par_valid (par_valid),
        .par_ready (lsb_ready),
        .ser_out   (lsb_out),
        .ser_valid (lsb_valid),
        .ser_first (lsb_first),
        .ser_last  (lsb_last),
        .busy      (lsb_busy)
    );

    piso_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) u_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .par_in    (par_in),
        .par_valid (par_valid),
        .par_ready (msb_ready),
        .ser_out   (msb_out),
        .ser_valid (msb_valid),
        .ser_first (msb_first),
        .ser_last  (msb_last),
        .busy      (msb_busy)
    );

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // The expected serial stream is a queue of bits; each accepted word appends one frame.
    task automatic pushFrame(input logic [WIDTH-1:0] d);
        exp_bit_t e;
        for (int i = 0; i < WIDTH; i++) begin
            e.first = (i == 0);
            e.last  = (i == WIDTH - 1) && !PAR_EN;
            e.b     = d[i];
            q_lsb.push_back(e);
            e.b     = d[WIDTH-1-i];
            q_msb.push_back(e);
        end
        if (PAR_EN) begin
            e.b     = ^d;
            e.first = 1'b0;
            e.last  = 1'b1;
            q_lsb.push_back(e);
            q_msb.push_back(e);
        end
        pending++;
    endtask

    task automatic popExpected();
        if (q_lsb.size() != 0) begin
            cur_lsb   = q_lsb.pop_front();
            cur_msb   = q_msb.pop_front();
            exp_valid = 1'b1;
            if (cur_lsb.first) pending--;
        end else begin
            cur_lsb   = '0;
            cur_msb   = '0;
            exp_valid = 1'b0;
        end
    endtask

    task automatic checkAll();
        logic exp_busy;
        logic exp_ready;
        exp_ready = (pending == 0);
        exp_busy  = exp_valid || (pending != 0);
        checkOutput("lsb_valid", lsb_valid, exp_valid);
        checkOutput("lsb_ready", lsb_ready, exp_ready);
        checkOutput("lsb_busy",  lsb_busy,  exp_busy);
        checkOutput("lsb_first", lsb_first, cur_lsb.first);
        checkOutput("lsb_last",  lsb_last,  cur_lsb.last);
        checkOutput("msb_valid", msb_valid, exp_valid);
        checkOutput("msb_ready", msb_ready, exp_ready);
        checkOutput("msb_busy",  msb_busy,  exp_busy);
        checkOutput("msb_first", msb_first, cur_msb.first);
        checkOutput("msb_last",  msb_last,  cur_msb.last);
        if (exp_valid) begin
            checkOutput("lsb_out", lsb_out, cur_lsb.b);
            checkOutput("msb_out", msb_out, cur_msb.b);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_lsb_out"},   lsb_out,   1'b0);
        checkOutput({tag, "_lsb_valid"}, lsb_valid, 1'b0);
        checkOutput({tag, "_lsb_first"}, lsb_first, 1'b0);
        checkOutput({tag, "_lsb_last"},  lsb_last,  1'b0);
        checkOutput({tag, "_lsb_busy"},  lsb_busy,  1'b0);
        checkOutput({tag, "_lsb_ready"}, lsb_ready, 1'b1);
        checkOutput({tag, "_msb_out"},   msb_out,   1'b0);
        checkOutput({tag, "_msb_valid"}, msb_valid, 1'b0);
        checkOutput({tag, "_msb_busy"},  msb_busy,  1'b0);
        checkOutput({tag, "_msb_ready"}, msb_ready, 1'b1);
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, output bit acc);
        @(negedge clk);
        par_valid = v;
        par_in    = d;
        acc       = v && (pending == 0) && rst_n;
        @(posedge clk);
        if (acc) pushFrame(d);
        popExpected();
        #1;
        checkAll();
    endtask

    task automatic drainIdle(input int bound);
        bit dummy;
        int n;
        n = 0;
        while ((q_lsb.size() != 0 || pending != 0) && n < bound) begin
            applyStimulus(1'b0, '0, dummy);
            n++;
        end
        applyStimulus(1'b0, '0, dummy);
    endtask

    initial begin
        bit               acc;
        int               idx;
        int               valid_cycles;
        logic             saw_not_ready;
        logic [WIDTH-1:0] words[3];

        checks   = 0;
        failures = 0;
        pending  = 0;
        cur_lsb  = '0;
        cur_msb  = '0;
        exp_valid = 1'b0;

        #2 rst_n = 1'b0;
        #1 checkReset("reset");
        applyStimulus(1'b0, '0, acc);
        #2 rst_n = 1'b1;
        $display("[TB] reset released");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, acc);

        $display("[TB] single frame 4'b1011");
        applyStimulus(1'b1, 4'b1011, acc);
        checkOutput("single_accept", lsb_valid, 1'b1);
        drainIdle(20);

        $display("[TB] back-to-back A,5,F");
        words[0] = 4'hA;
        words[1] = 4'h5;
        words[2] = 4'hF;
        idx = 0;
        valid_cycles = 0;
        saw_not_ready = 1'b0;
        for (int c = 0; c < 40 && idx < 3; c++) begin
            applyStimulus(1'b1, words[idx], acc);
            if (acc) idx++;
            if (lsb_valid) valid_cycles++;
            if (!lsb_ready) saw_not_ready = 1'b1;
        end
        checkOutput("b2b_all_accepted", idx == 3, 1'b1);
        for (int c = 0; c < 40 && lsb_valid; c++) begin
            applyStimulus(1'b0, '0, acc);
            if (lsb_valid) valid_cycles++;
        end
        checkOutput("b2b_contiguous_bits", valid_cycles == 3 * FRAME_LEN, 1'b1);
        checkOutput("b2b_ready_dropped", saw_not_ready, 1'b1);
        drainIdle(20);

        $display("[TB] directed words 1000, 0111, 0011");
        applyStimulus(1'b1, 4'b1000, acc);
        drainIdle(20);
        applyStimulus(1'b1, 4'b0111, acc);
        drainIdle(20);
        applyStimulus(1'b1, 4'b0011, acc);
        drainIdle(20);

        $display("[TB] mid-frame reset with hold full");
        applyStimulus(1'b1, 4'hC, acc);
        applyStimulus(1'b1, 4'h3, acc);
        applyStimulus(1'b0, '0, acc);
        checkOutput("pre_reset_hold_full", lsb_ready, 1'b0);
        #1 rst_n = 1'b0;
        #1 checkReset("midreset");
        q_lsb.delete();
        q_msb.delete();
        pending   = 0;
        cur_lsb   = '0;
        cur_msb   = '0;
        exp_valid = 1'b0;
        applyStimulus(1'b0, '0, acc);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, acc);
        applyStimulus(1'b1, 4'h6, acc);
        drainIdle(20);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, WIDTH'($urandom), acc);
        end
        drainIdle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
